// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: drives the ALU opcode, registers results into EX/MEM, owns {N,V,Z} and resolves branches.
// One-cycle latency into EX/MEM at full throughput; decode stalls while EX/MEM is full and MEM is not ready, and intake stops permanently after HLT.
module alu_exec_ctrl #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [3:0]    id_opcode,
    input  logic [2:0]    id_ccc,
    input  logic [RW-1:0] id_rd,
    input  logic          id_wen,
    output logic [3:0]    alu_opcode,
    input  logic [DW-1:0] alu_out,
    input  logic [2:0]    alu_flag,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [DW-1:0] ex_result,
    output logic [RW-1:0] ex_rd,
    output logic          ex_wen,
    output logic          ex_mem_rd,
    output logic          ex_mem_wr,
    output logic          br_taken,
    output logic [2:0]    flags,
    output logic          halted
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_LW  = 4'd8;
    localparam logic [3:0] OP_SW  = 4'd9;
    localparam logic [3:0] OP_B   = 4'd12;
    localparam logic [3:0] OP_BR  = 4'd13;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic xfer;
    logic is_branch;
    logic is_halt;
    logic ld_nvz;
    logic ld_z;
    logic cond_ok;
    logic n_f;
    logic v_f;
    logic z_f;

    assign alu_opcode = id_opcode;
    assign halted     = (state == ST_HALT);
    assign accept     = id_valid & id_ready;
    assign xfer       = ex_valid & ex_ready;
    assign is_branch  = (id_opcode == OP_B) | (id_opcode == OP_BR);
    assign is_halt    = (id_opcode == OP_HLT);
    assign ld_nvz     = (id_opcode == OP_ADD) | (id_opcode == OP_SUB);
    assign ld_z       = (id_opcode >= OP_XOR) & (id_opcode <= OP_ROR);
    assign {n_f, v_f, z_f} = flags;

    // Conditions look at the flag register as it stands at accept, before this instruction's own update.
    always_comb begin
        cond_ok = 1'b0;
        case (id_ccc)
            3'b000:  cond_ok = ~z_f;
            3'b001:  cond_ok = z_f;
            3'b010:  cond_ok = ~z_f & ~n_f;
            3'b011:  cond_ok = n_f;
            3'b100:  cond_ok = z_f | (~z_f & ~n_f);
            3'b101:  cond_ok = n_f | z_f;
            3'b110:  cond_ok = v_f;
            default: cond_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        id_ready  = 1'b0;
        case (state)
            ST_RUN, ST_HOLD: begin
                id_ready = ~ex_valid | ex_ready;
                if (id_valid && id_ready && is_halt) begin
                    state_nxt = ST_HALT;
                end else if (ex_valid && !ex_ready) begin
                    state_nxt = ST_HOLD;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_result <= '0;
            ex_rd     <= '0;
            ex_wen    <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
            br_taken  <= 1'b0;
            flags     <= 3'b000;
        end else begin
            br_taken <= accept & is_branch & cond_ok;
            if (accept) begin
                ex_valid  <= 1'b1;
                ex_result <= alu_out;
                ex_rd     <= id_rd;
                ex_wen    <= id_wen & ~is_branch & ~is_halt;
                ex_mem_rd <= (id_opcode == OP_LW);
                ex_mem_wr <= (id_opcode == OP_SW);
                if (ld_nvz) begin
                    flags <= alu_flag;
                end else if (ld_z) begin
                    flags[0] <= alu_flag[0];
                end
            end else if (xfer) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboarded bench for alu_exec_ctrl: the bench plays decode, ALU and MEM, predicting every output from an abstract model.
module tb_alu_exec_ctrl;

    localparam int DW = 16;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic          id_ready;
    logic [3:0]    id_opcode;
    logic [2:0]    id_ccc;
    logic [RW-1:0] id_rd;
    logic          id_wen;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_out;
    logic [2:0]    alu_flag;
    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] ex_result;
    logic [RW-1:0] ex_rd;
    logic          ex_wen;
    logic          ex_mem_rd;
    logic          ex_mem_wr;
    logic          br_taken;
    logic [2:0]    flags;
    logic          halted;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_opcode(id_opcode), .id_ccc(id_ccc),
        .id_rd(id_rd), .id_wen(id_wen), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .alu_flag(alu_flag), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .br_taken(br_taken), .flags(flags), .halted(halted)
    );

    typedef struct packed {
        logic [DW-1:0] res;
        logic [RW-1:0] rd;
        logic          wen;
        logic          mrd;
        logic          mwr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Abstract architectural state: flag register, EX/MEM occupancy, halt, expected branch pulse.
    logic [2:0] flags_m;
    logic       occ_m;
    logic       halt_m;
    logic       br_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] f);
        bit n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] next_flags(input int op, input logic [2:0] f, input logic [2:0] af);
        if (op == 0 || op == 1) return af;
        if (op >= 2 && op <= 6) return {f[2:1], af[0]};
        return f;
    endfunction

    // Drive one cycle of stimulus (called just after a rising edge), predict, then check after the edge.
    task automatic step(input logic v, input int op, input int c, input int rd, input logic w,
                        input logic [DW-1:0] ao, input logic [2:0] af, input logic er);
        logic exp_rdy;
        logic acc;
        exp_t e;
        id_valid  = v;
        id_opcode = 4'(op);
        id_ccc    = 3'(c);
        id_rd     = RW'(rd);
        id_wen    = w;
        alu_out   = ao;
        alu_flag  = af;
        ex_ready  = er;
        @(negedge clk);
        exp_rdy = !halt_m && (!occ_m || er);
        chk("id_ready", 32'(id_ready), 32'(exp_rdy));
        chk("alu_opcode", 32'(alu_opcode), 32'(op));
        acc  = v && exp_rdy;
        br_m = 1'b0;
        if (acc) begin
            e.res = ao;
            e.rd  = RW'(rd);
            e.wen = w && !(op == 12 || op == 13 || op == 15);
            e.mrd = (op == 8);
            e.mwr = (op == 9);
            sb.push_back(e);
            br_m    = (op == 12 || op == 13) && cond_holds(3'(c), flags_m);
            flags_m = next_flags(op, flags_m, af);
            if (op == 15) halt_m = 1'b1;
            occ_m = 1'b1;
        end else if (er) begin
            occ_m = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("br_taken", 32'(br_taken), 32'(br_m));
        chk("flags", 32'(flags), 32'(flags_m));
        chk("halted", 32'(halted), 32'(halt_m));
        chk("ex_valid", 32'(ex_valid), 32'(occ_m));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        id_valid = 1'b1;
        ex_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        id_valid = 1'b0;
        sb.delete();
        flags_m = 3'b000;
        occ_m   = 1'b0;
        halt_m  = 1'b0;
        br_m    = 1'b0;
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_ex_result", 32'(ex_result), 0);
        chk("rst_ex_rd", 32'(ex_rd), 0);
        chk("rst_ex_ctl", {29'd0, ex_wen, ex_mem_rd, ex_mem_wr}, 0);
        chk("rst_br_taken", 32'(br_taken), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_id_ready", 32'(id_ready), 1);
    endtask

    // Monitor: every MEM transfer must deliver the oldest accepted instruction unchanged.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_xfer", 32'(ex_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ex_result", 32'(ex_result), 32'(e.res));
                chk("ex_rd", 32'(ex_rd), 32'(e.rd));
                chk("ex_wen", 32'(ex_wen), 32'(e.wen));
                chk("ex_mem_rd", 32'(ex_mem_rd), 32'(e.mrd));
                chk("ex_mem_wr", 32'(ex_mem_wr), 32'(e.mwr));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        id_valid  = 1'b0;
        id_opcode = 4'd0;
        id_ccc    = 3'd0;
        id_rd     = '0;
        id_wen    = 1'b0;
        alu_out   = '0;
        alu_flag  = 3'b000;
        ex_ready  = 1'b0;
        flags_m   = 3'b000;
        occ_m     = 1'b0;
        halt_m    = 1'b0;
        br_m      = 1'b0;
        do_reset();

        // ADD loads N,V,Z; XOR loads Z only; LLB leaves flags alone
        step(1, 0, 0, 3, 1, 16'h8000, 3'b110, 1);
        step(1, 2, 0, 4, 1, 16'h1234, 3'b001, 1);
        step(1, 10, 0, 5, 1, 16'h00ab, 3'b000, 1);

        // SUB sets Z, then branch on Z=1 (taken) and on Z=0 (not taken)
        step(1, 1, 0, 6, 1, 16'h0000, 3'b001, 1);
        step(1, 12, 1, 7, 1, 16'h0040, 3'b000, 1);
        step(1, 1, 0, 6, 1, 16'h0000, 3'b001, 1);
        step(1, 12, 0, 7, 1, 16'h0040, 3'b000, 1);
        step(1, 14, 0, 2, 1, 16'h0102, 3'b000, 1);
        step(1, 8, 0, 1, 1, 16'h0200, 3'b000, 1);
        step(1, 9, 0, 1, 0, 16'h0300, 3'b000, 1);

        // Back-pressure: three stalled cycles, then accept and transfer together
        step(1, 0, 0, 9, 1, 16'hbeef, 3'b010, 1);
        for (int i = 0; i < 3; i++) step(1, 3, 0, 10, 1, 16'h5555, 3'b001, 0);
        step(1, 3, 0, 10, 1, 16'h5555, 3'b001, 1);
        step(1, 4, 0, 11, 1, 16'h6666, 3'b000, 1);

        // HLT: EX/MEM still drains, intake and flags frozen, reset recovers
        step(1, 15, 0, 12, 1, 16'h7777, 3'b111, 1);
        step(1, 0, 0, 1, 1, 16'h1111, 3'b111, 0);
        step(1, 0, 0, 1, 1, 16'h1111, 3'b111, 0);
        step(1, 0, 0, 1, 1, 16'h1111, 3'b111, 1);
        step(1, 1, 0, 1, 1, 16'h2222, 3'b101, 1);
        do_reset();

        // Reset while an instruction is held discards it
        step(1, 0, 0, 2, 1, 16'h4321, 3'b100, 1);
        step(1, 0, 0, 2, 1, 16'h4321, 3'b100, 0);
        do_reset();

        // Every condition code against every flag value
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                step(1, 0, 0, 1, 1, 16'(f), 3'(f), 1);
                step(1, 12 + (c % 2), c, 2, 1, 16'h0010, 3'b000, 1);
            end
        end

        // Randomized traffic with random back-pressure, occasional HLT and reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                int op;
                op = ($urandom_range(0, 39) == 0) ? 15 : int'($urandom_range(0, 14));
                step(($urandom_range(0, 3) != 0), op, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 15)), 1'($urandom), 16'($urandom),
                     3'($urandom), ($urandom_range(0, 3) != 0));
            end
        end

        step(0, 0, 0, 0, 0, 16'h0, 3'b000, 1);
        step(0, 0, 0, 0, 0, 16'h0, 3'b000, 1);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
